// File: rtl/fir_pkg.sv
// Types and constants shared between the FIR filter and its output serializer.
package fir_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } ser_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous word FIFO with a registered head word and an occupancy count.
module fir_sample_fifo #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [N-1:0]             din,
  output logic [N-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = AW'(rd_ptr + 1'b1);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= AW'(wr_ptr + 1'b1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_next;
      end
      // Head register tracks whichever word will sit at rd_ptr next cycle.
      if (push_ok && (empty || (pop_ok && level == LW'(1)))) begin
        dout <= din;
      end else if (pop_ok) begin
        dout <= mem[rd_next];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level <= LW'(level + 1'b1);
        2'b01:   level <= LW'(level - 1'b1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_serializer.sv
// Decimates the FIR output stream, buffers it, and ships each word MSB-first on a framed link.
module fir_out_serializer
  import fir_pkg::*;
#(
  parameter int unsigned N       = SAMPLE_W,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DECIM   = 4,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           sample_in,
  input  logic                   sample_valid,
  input  logic                   enable,
  output logic                   ser_clk,
  output logic                   ser_data,
  output logic                   ser_frame,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned DW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned CW   = $clog2(CLK_DIV);
  localparam int unsigned BW   = $clog2(N);
  localparam int unsigned HALF = CLK_DIV / 2;

  ser_state_t    state;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] dv;
  logic [CW-1:0] dv_inc;
  logic [BW-1:0] bcnt;
  logic [N-1:0]  sreg;
  logic [N-1:0]  fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          capture;
  logic          pop;

  assign capture = sample_valid && enable && (dcnt == '0);
  assign pop     = (state == LOAD);
  assign dv_inc  = CW'(dv + 1'b1);

  // Decimator: held at zero while disabled so the first sample after enable is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt <= '0;
    end else if (!enable) begin
      dcnt <= '0;
    end else if (sample_valid) begin
      dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : DW'(dcnt + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (capture && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  fir_sample_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .din   (sample_in),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are assigned alongside the transition that produces them, so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dv        <= '0;
      bcnt      <= '0;
      sreg      <= '0;
      ser_clk   <= 1'b0;
      ser_data  <= 1'b0;
      ser_frame <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          sreg      <= fifo_dout;
          dv        <= '0;
          bcnt      <= '0;
          state     <= SHIFT;
          ser_frame <= 1'b1;
          ser_data  <= fifo_dout[N-1];
          ser_clk   <= 1'b0;
        end
        SHIFT: begin
          if (dv == CW'(CLK_DIV - 1)) begin
            dv      <= '0;
            ser_clk <= 1'b0;
            if (bcnt == BW'(N - 1)) begin
              state     <= GAP;
              ser_frame <= 1'b0;
              ser_data  <= 1'b0;
            end else begin
              bcnt     <= BW'(bcnt + 1'b1);
              sreg     <= {sreg[N-2:0], 1'b0};
              ser_data <= sreg[N-2];
            end
          end else begin
            dv      <= dv_inc;
            ser_clk <= (dv_inc >= CW'(HALF));
          end
        end
        GAP: begin
          if (dv == CW'(CLK_DIV - 1)) begin
            dv <= '0;
            if (!fifo_empty) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dv <= dv_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Scoreboard bench: stimulus queues expected words, a serial-link monitor decodes and compares.
module tb_fir_out_serializer;

  localparam int N       = 16;
  localparam int DEPTH   = 8;
  localparam int DECIM   = 4;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        enable = 1'b0;
  logic        ser_clk;
  logic        ser_data;
  logic        ser_frame;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb[$];
  int          frame_starts = 0;
  int          last_gap = 0;

  fir_out_serializer #(
    .N       (N),
    .DEPTH   (DEPTH),
    .DECIM   (DECIM),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .enable       (enable),
    .ser_clk      (ser_clk),
    .ser_data     (ser_data),
    .ser_frame    (ser_frame),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial-link monitor: samples at the falling clk edge, decodes on ser_clk rises.
  initial begin
    logic        prev_frame;
    logic        prev_sclk;
    logic [15:0] word;
    logic [15:0] exp_w;
    int          fcyc;
    int          bitcnt;
    int          gap_cnt;
    prev_frame = 1'b0;
    prev_sclk  = 1'b0;
    word       = '0;
    fcyc       = 0;
    bitcnt     = 0;
    gap_cnt    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_frame = 1'b0;
        prev_sclk  = 1'b0;
        fcyc       = 0;
        bitcnt     = 0;
        gap_cnt    = 0;
      end else begin
        if (ser_frame && !prev_frame) begin
          frame_starts++;
          last_gap = gap_cnt;
          fcyc     = 0;
          bitcnt   = 0;
        end
        if (ser_frame) begin
          fcyc++;
          if (ser_clk && !prev_sclk) begin
            word = {word[14:0], ser_data};
            bitcnt++;
          end
        end else if (prev_frame) begin
          check("frame_len", fcyc, N * CLK_DIV);
          check("frame_bits", bitcnt, N);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h expected no frame", word);
          end else begin
            exp_w = sb.pop_front();
            check("word", word, exp_w);
          end
          gap_cnt = 1;
        end else begin
          gap_cnt++;
        end
        prev_frame = ser_frame;
        prev_sclk  = ser_clk;
      end
    end
  end

  task automatic drive(input logic [15:0] d, input logic v, input logic en);
    sample_in    = d;
    sample_valid = v;
    enable       = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    enable       = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int timed_out;
    timed_out    = 1;
    sample_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy && fifo_level == 0 && !ser_frame) begin
        timed_out = 0;
        break;
      end
    end
    check({name, "_timeout"}, timed_out, 0);
    check({name, "_queue_left"}, sb.size(), 0);
  endtask

  initial begin
    int fs0;
    int prev;
    int found;

    // Reset state
    do_reset();
    check("rst_ser_clk", ser_clk, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_ser_frame", ser_frame, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);

    // Single word latency and framing
    sb.push_back(16'hA5C3);
    drive(16'hA5C3, 1'b1, 1'b1);
    check("lat_level_k", fifo_level, 1);
    check("lat_frame_k", ser_frame, 0);
    drive(16'h0000, 1'b0, 1'b1);
    check("lat_busy_k1", busy, 1);
    check("lat_frame_k1", ser_frame, 0);
    drive(16'h0000, 1'b0, 1'b1);
    check("lat_frame_k2", ser_frame, 1);
    check("lat_msb_k2", ser_data, 1);
    check("lat_level_k2", fifo_level, 0);
    wait_idle("single");
    check("single_busy_end", busy, 0);

    // Decimation: only samples 1 and 5 of 1..8 are captured
    do_reset();
    fs0 = frame_starts;
    sb.push_back(16'd1);
    sb.push_back(16'd5);
    for (int i = 1; i <= 8; i++) drive(16'(i), 1'b1, 1'b1);
    wait_idle("decim");
    check("decim_frames", frame_starts - fs0, 2);
    check("decim_gap", last_gap, CLK_DIV + 1);

    // Overflow: 12 captures back to back, words 10..12 dropped
    do_reset();
    fs0 = frame_starts;
    for (int k = 1; k <= 9; k++) sb.push_back(16'(k));
    for (int i = 0; i < 48; i++) begin
      drive(16'((i / DECIM) + 1), 1'b1, 1'b1);
      if (i == 32) check("ovf_before_full", overflow, 0);
    end
    check("ovf_level_full", fifo_level, DEPTH);
    check("ovf_set", overflow, 1);
    wait_idle("ovf");
    check("ovf_frames", frame_starts - fs0, 9);
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared", overflow, 0);

    // Enable gating
    fs0 = frame_starts;
    for (int i = 0; i < 20; i++) drive(16'h1111, 1'b1, 1'b0);
    check("gate_level", fifo_level, 0);
    check("gate_busy", busy, 0);
    check("gate_frames", frame_starts - fs0, 0);
    sb.push_back(16'hBEEF);
    drive(16'hBEEF, 1'b1, 1'b1);
    check("gate_capture", fifo_level, 1);
    wait_idle("gate");

    // Reset during bit 5 with three words queued
    do_reset();
    sb.push_back(16'h1234);
    sb.push_back(16'h5678);
    sb.push_back(16'h9ABC);
    sb.push_back(16'hDEF0);
    for (int i = 0; i < 16; i++) begin
      case (i / 4)
        0:       drive(16'h1234, 1'b1, 1'b1);
        1:       drive(16'h5678, 1'b1, 1'b1);
        2:       drive(16'h9ABC, 1'b1, 1'b1);
        default: drive(16'hDEF0, 1'b1, 1'b1);
      endcase
    end
    for (int i = 0; i < 9; i++) drive(16'h0000, 1'b0, 1'b1);
    check("midrst_in_frame", ser_frame, 1);
    check("midrst_level_pre", fifo_level, 3);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_ser_clk", ser_clk, 0);
    check("midrst_ser_data", ser_data, 0);
    check("midrst_ser_frame", ser_frame, 0);
    check("midrst_busy", busy, 0);
    check("midrst_level", fifo_level, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fs0 = frame_starts;
    for (int i = 0; i < 120; i++) drive(16'h0000, 1'b0, 1'b1);
    check("midrst_no_frames", frame_starts - fs0, 0);
    check("midrst_idle", busy, 0);

    // Push during LOAD with the FIFO full
    do_reset();
    for (int k = 1; k <= 9; k++) sb.push_back(16'((k << 12) | k));
    sb.push_back(16'hFACE);
    for (int i = 0; i < 36; i++) drive(16'((((i / 4) + 1) << 12) | ((i / 4) + 1)), 1'b1, 1'b1);
    check("coll_full", fifo_level, DEPTH);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      prev = int'(ser_frame);
      drive(16'h0000, 1'b0, 1'b1);
      if (prev == 1 && !ser_frame) begin
        found = 1;
        break;
      end
    end
    check("coll_frame_end_seen", found, 1);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b1);
    drive(16'h0000, 1'b0, 1'b1);
    drive(16'h0000, 1'b0, 1'b1);
    check("coll_level_pre", fifo_level, DEPTH);
    check("coll_busy_pre", busy, 1);
    drive(16'hFACE, 1'b1, 1'b1);
    check("coll_level_post", fifo_level, DEPTH);
    check("coll_no_ovf", overflow, 0);
    wait_idle("coll");
    check("coll_no_ovf_end", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_out_serializer.md
# fir_out_serializer

Drains the 16-bit output stream of the FIR filter and ships it off-chip as serial words. Filtered samples are decimated by a fixed ratio and buffered in a small FIFO. Each buffered word is then shifted out MSB-first on a framed serial link (ser_clk / ser_data / ser_frame). The block sits directly downstream of the filter's registered output, on the same clock.

## Interface
- N, 16: sample width in bits.
- DEPTH, 8: FIFO depth in words; must be a power of 2, ≥ 2.
- DECIM, 4: capture one accepted sample in every DECIM; 1 captures every sample.
- CLK_DIV, 4: clk cycles per serial bit; must be even, ≥ 2.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- sample_in  in  N  filtered sample (unsigned bit pattern, passed through unchanged).
- sample_valid  in  1  sample_in is valid this cycle.
- enable  in  1  capture enable; the FIFO keeps draining while low.
- ser_clk  out  1  serial bit clock; receiver samples on its rising edge.
- ser_data  out  1  serial data, MSB first.
- ser_frame  out  1  high for exactly the N bits of one word.
- busy  out  1  FSM is not in IDLE.
- overflow  out  1  sticky; set when a capture is dropped; cleared only by reset.
- fifo_level  out  $clog2(DEPTH)+1  number of words held in the FIFO.

## Operation
- Decimator: counter dcnt runs 0..DECIM-1 and advances on each cycle where sample_valid && enable.
  - The sample is captured (FIFO push) when dcnt==0.
  - While enable is low, dcnt is held at 0. The first valid sample after enable rises is therefore captured.
- FIFO push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - A simultaneous push and pop leaves fifo_level unchanged. Word order is preserved.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE: if fifo_level != 0, go to LOAD.
  - LOAD: one cycle. Pop the head word into shift register sreg, clear the bit and divider counters, go to SHIFT.
  - SHIFT: ser_frame=1, ser_data=sreg[N-1]. Divider counter dv runs 0..CLK_DIV-1, with ser_clk = (dv ≥ CLK_DIV/2). When dv wraps, sreg shifts left. After N bits, go to GAP.
  - GAP: CLK_DIV cycles with ser_frame=0, ser_clk=0, ser_data=0. Then go to LOAD if fifo_level != 0, else IDLE.
- Outside SHIFT: ser_clk=0, ser_data=0, ser_frame=0.
- All outputs are registered.

## Timing
- Reset values: ser_clk=0, ser_data=0, ser_frame=0, busy=0, overflow=0, fifo_level=0, dcnt=0, state=IDLE.
- Reset mid-frame: the frame is aborted asynchronously and the FIFO is emptied. No partial word is resumed after reset.
- Latency, for a captured sample at edge k into an empty, idle block:
  - after edge k: fifo_level=1.
  - after edge k+1: state=LOAD, busy=1.
  - after edge k+2: ser_frame=1, ser_data=MSB, fifo_level=0.
- Frame length is exactly N·CLK_DIV cycles. Bit i occupies cycles [i·CLK_DIV, (i+1)·CLK_DIV) of the frame. The ser_clk rising edge falls at mid-bit.
- Back-to-back words: ser_frame is low for exactly CLK_DIV+1 cycles (GAP, then LOAD). Steady-state throughput is one word per (N+1)·CLK_DIV+1 cycles.
- Overflow-free operation therefore requires DECIM·(sample interval) ≥ (N+1)·CLK_DIV+1 on average. Bursts are absorbed up to DEPTH words.

## Structure
- Shared package fir_pkg:
  - SAMPLE_W = 16, shared with the FIR filter.
  - FSM state enum ser_state_t {IDLE, LOAD, SHIFT, GAP}.
- One sub-module: fir_sample_fifo, a synchronous FIFO parameterised on N and DEPTH.
  - Ports: push, pop, din, dout, level, full, empty.
  - Registered head output (dout = head word).
  - Same clk and async reset.
- Top level contains the decimator, FSM, divider/bit counters and the shift register.

## Test plan
- Single word, defaults: capture 16'hA5C3. ser_frame is high for 64 cycles starting 2 cycles after the level goes to 1. ser_data sampled at ser_clk rising edges reads 1010_0101_1100_0011. busy returns to 0 after GAP.
- Decimation, DECIM=4, enable=1: samples 1..8 valid on consecutive cycles. Only words 1 and 5 are transmitted, in that order. Inter-frame low time is 5 cycles.
- Overflow, DECIM=1, DEPTH=8: 12 consecutive valid samples 1..12 into an idle block. Words 1..9 are transmitted in order, 10..12 are dropped, overflow=1 and stays 1 until reset.
- Enable gating: enable=0 with 20 valid samples gives fifo_level=0 and no frames. Raising enable captures the next valid sample immediately.
- Reset mid-frame: assert reset during bit 5 of a word with 3 words queued. All outputs are 0 in the same cycle and fifo_level=0. After deassert, no frame occurs until a new capture.
- Push/pop collision: with the FIFO full, push during a LOAD cycle. The word is accepted, fifo_level stays at DEPTH, and overflow stays 0.
